// File: rtl/fabric_pe_elastic.sv
// Elastic processing element: fire when all operands are valid and every output FIFO has room
// for everything in flight. Perf counters are built only with FABRIC_PE_ELASTIC_PERF_EN.
module fabric_pe_elastic #(
    parameter int NUM_INPUTS  = 2,
    parameter int NUM_OUTPUTS = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int TAG_WIDTH   = 0,
    parameter int LATENCY     = 2,
    parameter int OUT_DEPTH   = 4,
    localparam int PW         = DATA_WIDTH + TAG_WIDTH,
    localparam int CFG_W      = NUM_OUTPUTS * TAG_WIDTH + 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_INPUTS-1:0]              in_valid,
    output logic [NUM_INPUTS-1:0]              in_ready,
    input  logic [NUM_INPUTS*PW-1:0]           in_data,
    output logic [NUM_OUTPUTS-1:0]             out_valid,
    input  logic [NUM_OUTPUTS-1:0]             out_ready,
    output logic [NUM_OUTPUTS*PW-1:0]          out_data,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0]   body_operands,
    input  logic [NUM_OUTPUTS*DATA_WIDTH-1:0]  body_result,
    input  logic [CFG_W-1:0]                   cfg_data,
    output logic [31:0]                        perf_fire_cnt,
    output logic [31:0]                        perf_stall_cnt
);

    localparam int TW1 = (TAG_WIDTH > 0) ? TAG_WIDTH : 1;
    localparam int SN  = (LATENCY > 0) ? LATENCY : 1;
    localparam int AW  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CW  = AW + 1;
    localparam int RW  = NUM_OUTPUTS * DATA_WIDTH;

    if (NUM_INPUTS < 1 || NUM_OUTPUTS < 1 || DATA_WIDTH < 1 || TAG_WIDTH < 0 || LATENCY < 0 ||
        OUT_DEPTH < 2 || (OUT_DEPTH & (OUT_DEPTH - 1)) != 0) begin : g_param_check
        $fatal(1, "fabric_pe_elastic: parameter out of range");
    end

    logic                      all_valid;
    logic                      credit_ok;
    logic                      fire;
    logic [31:0]               inflight;
    logic [NUM_OUTPUTS*CW-1:0] count_all;
    logic [TW1-1:0]            in_tag;
    logic                      push;
    logic [RW-1:0]             push_data;
    logic [TW1-1:0]            push_tag;
    logic                      unused_bits;

    assign unused_bits = ^{cfg_data, in_data, push_tag};

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_operands
        assign body_operands[i*DATA_WIDTH +: DATA_WIDTH] = in_data[i*PW +: DATA_WIDTH];
    end

    if (TAG_WIDTH > 0) begin : g_in_tag
        assign in_tag = in_data[PW-1 -: TAG_WIDTH];
    end else begin : g_no_in_tag
        assign in_tag = '0;
    end

    // Credit check uses registered state only, so in_ready never depends on out_ready.
    always_comb begin
        credit_ok = 1'b1;
        for (int o = 0; o < NUM_OUTPUTS; o++) begin
            if (32'(count_all[o*CW +: CW]) + inflight >= 32'(OUT_DEPTH)) begin
                credit_ok = 1'b0;
            end
        end
    end

    assign all_valid = &in_valid;
    assign fire      = rst_n & all_valid & credit_ok;
    assign in_ready  = {NUM_INPUTS{fire}};

    if (LATENCY > 0) begin : g_pipe
        logic [SN-1:0]  stg_valid_q;
        logic [RW-1:0]  stg_data_q [SN];
        logic [TW1-1:0] stg_tag_q  [SN];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stg_valid_q <= '0;
            end else begin
                stg_valid_q[0] <= fire;
                for (int k = 1; k < SN; k++) begin
                    stg_valid_q[k] <= stg_valid_q[k-1];
                end
            end
        end

        // Payload captured unconditionally; only the valid bits qualify it.
        always_ff @(posedge clk) begin
            stg_data_q[0] <= body_result;
            stg_tag_q[0]  <= in_tag;
            for (int k = 1; k < SN; k++) begin
                stg_data_q[k] <= stg_data_q[k-1];
                stg_tag_q[k]  <= stg_tag_q[k-1];
            end
        end

        always_comb begin
            inflight = '0;
            for (int k = 0; k < SN; k++) begin
                inflight = inflight + 32'(stg_valid_q[k]);
            end
        end

        assign push      = stg_valid_q[SN-1];
        assign push_data = stg_data_q[SN-1];
        assign push_tag  = stg_tag_q[SN-1];
    end else begin : g_nopipe
        assign inflight  = '0;
        assign push      = fire;
        assign push_data = body_result;
        assign push_tag  = in_tag;
    end

    for (genvar o = 0; o < NUM_OUTPUTS; o++) begin : g_out
        logic [PW-1:0] mem [OUT_DEPTH];
        logic [AW-1:0] wr_q;
        logic [AW-1:0] rd_q;
        logic [CW-1:0] count_q;
        logic          pop;
        logic [PW-1:0] wr_entry;

        if (TAG_WIDTH > 0) begin : g_tag
            logic [TW1-1:0] tag_sel;
            assign tag_sel  = cfg_data[CFG_W-1] ? push_tag : cfg_data[o*TAG_WIDTH +: TAG_WIDTH];
            assign wr_entry = {tag_sel, push_data[o*DATA_WIDTH +: DATA_WIDTH]};
        end else begin : g_notag
            assign wr_entry = push_data[o*DATA_WIDTH +: DATA_WIDTH];
        end

        assign out_valid[o]              = (count_q != '0);
        assign out_data[o*PW +: PW]      = mem[rd_q];
        assign count_all[o*CW +: CW]     = count_q;
        assign pop                       = out_valid[o] & out_ready[o];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_q    <= '0;
                rd_q    <= '0;
                count_q <= '0;
            end else begin
                if (push) wr_q <= wr_q + 1'b1;
                if (pop)  rd_q <= rd_q + 1'b1;
                if (push && !pop) begin
                    count_q <= count_q + 1'b1;
                end else if (!push && pop) begin
                    count_q <= count_q - 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (push) mem[wr_q] <= wr_entry;
        end

        assert property (@(posedge clk) disable iff (!rst_n)
                         !(push && count_q == CW'(OUT_DEPTH)));
    end

`ifdef FABRIC_PE_ELASTIC_PERF_EN
    logic [31:0] fire_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fire_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (fire && fire_cnt_q != '1) fire_cnt_q <= fire_cnt_q + 32'd1;
            if (all_valid && !credit_ok && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign perf_fire_cnt  = fire_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`else
    assign perf_fire_cnt  = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fabric_pe_elastic.sv
// Scoreboard bench for fabric_pe_elastic: two 8-bit operands, 2-bit tags, body = a + b.
module tb_fabric_pe_elastic;

    localparam int PW = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  in_valid;
    logic [1:0]  in_ready;
    logic [19:0] in_data;
    logic [1:0]  out_valid;
    logic [1:0]  out_ready;
    logic [19:0] out_data;
    logic [15:0] body_operands;
    logic [15:0] body_result;
    logic [4:0]  cfg_data;
    logic [31:0] perf_fire_cnt;
    logic [31:0] perf_stall_cnt;
    logic [7:0]  body_sum;

    fabric_pe_elastic #(
        .NUM_INPUTS (2),
        .NUM_OUTPUTS(2),
        .DATA_WIDTH (8),
        .TAG_WIDTH  (2),
        .LATENCY    (2),
        .OUT_DEPTH  (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .body_operands (body_operands),
        .body_result   (body_result),
        .cfg_data      (cfg_data),
        .perf_fire_cnt (perf_fire_cnt),
        .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 clk = ~clk;

    assign body_sum    = body_operands[7:0] + body_operands[15:8];
    assign body_result = {body_sum, body_sum};

    int errors = 0;
    int checks = 0;
    int fires  = 0;
    int pops0  = 0;
    int pops1  = 0;
    int n;
    int f0;
    int p0;
    int p1;
    bit found;
    logic [PW-1:0] exp0[$];
    logic [PW-1:0] exp1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] expect_word(input int o);
        logic [7:0] s;
        logic [1:0] t;
        s = in_data[7:0] + in_data[17:10];
        if (cfg_data[4]) t = in_data[9:8];
        else if (o == 0) t = cfg_data[1:0];
        else t = cfg_data[3:2];
        return {t, s};
    endfunction

    // Monitor: inputs settle after posedge, so the negedge sees exactly what the next edge commits.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid == 2'b11 && in_ready == 2'b11) begin
                fires++;
                exp0.push_back(expect_word(0));
                exp1.push_back(expect_word(1));
            end
            if (out_valid[0] && out_ready[0]) begin
                pops0++;
                if (exp0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_port0: got unexpected %0h, expected no output", out_data[9:0]);
                end else begin
                    check("sb_port0", 32'(out_data[9:0]), 32'(exp0.pop_front()));
                end
            end
            if (out_valid[1] && out_ready[1]) begin
                pops1++;
                if (exp1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_port1: got unexpected %0h, expected no output", out_data[19:10]);
                end else begin
                    check("sb_port1", 32'(out_data[19:10]), 32'(exp1.pop_front()));
                end
            end
        end
    end

    task automatic tick(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp0.delete();
        exp1.delete();
        tick(2);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        in_valid  = 2'b11;
        in_data   = {2'b00, 8'd4, 2'b00, 8'd3};
        out_ready = 2'b11;
        cfg_data  = 5'b0_10_01;
        #12;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_perf_fire", perf_fire_cnt, 32'd0);
        check("reset_perf_stall", perf_stall_cnt, 32'd0);
        in_valid = 2'b00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 3 + 4 held valid: first result three cycles after fire, then one per cycle.
        in_valid = 2'b11;
        @(negedge clk);
        check("first_fire", 32'(in_ready), 32'd3);
        n = 0;
        found = 1'b0;
        for (int k = 1; k <= 10 && !found; k++) begin
            @(negedge clk);
            if (out_valid == 2'b11) begin
                found = 1'b1;
                n = k;
            end
        end
        check("fire_to_valid_latency", 32'(n), 32'd3);
        check("port0_result_tag01", 32'(out_data[9:0]), 32'({2'b01, 8'd7}));
        check("port1_result_tag10", 32'(out_data[19:10]), 32'({2'b10, 8'd7}));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("streaming_valid", 32'(out_valid), 32'd3);
        end
        tick(1);
        in_valid = 2'b00;
        tick(8);
        check("throughput_fires", 32'(fires), 32'd7);

        // Perf scenario: 6 free-flowing fires, then port 1 stalled for 9 valid cycles.
        do_reset();
        f0 = fires;
        in_data  = {2'b00, 8'd20, 2'b00, 8'd10};
        in_valid = 2'b11;
        tick(6);
        in_valid = 2'b00;
        tick(6);
        check("phase_a_fires", 32'(fires - f0), 32'd6);

        f0 = fires;
        p0 = pops0;
        p1 = pops1;
        out_ready = 2'b01;
        in_data   = {2'b00, 8'd6, 2'b00, 8'd5};
        in_valid  = 2'b11;
        tick(8);
        @(negedge clk);
        check("credit_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 2'b00;
        tick(6);
        check("credit_fires", 32'(fires - f0), 32'd4);
        check("port0_drained", 32'(pops0 - p0), 32'd4);
        check("port1_no_pops", 32'(pops1 - p1), 32'd0);
        check("port1_holding", 32'(out_valid[1]), 32'd1);
`ifdef FABRIC_PE_ELASTIC_PERF_EN
        check("perf_fire_cnt", perf_fire_cnt, 32'd10);
        check("perf_stall_cnt", perf_stall_cnt, 32'd5);
`else
        check("perf_fire_cnt", perf_fire_cnt, 32'd0);
        check("perf_stall_cnt", perf_stall_cnt, 32'd0);
`endif

        // One pop on port 1 frees exactly one credit.
        f0 = fires;
        p1 = pops1;
        in_valid  = 2'b11;
        out_ready = 2'b11;
        tick(1);
        out_ready = 2'b01;
        tick(7);
        in_valid = 2'b00;
        check("one_credit_fire", 32'(fires - f0), 32'd1);
        check("one_credit_pop", 32'(pops1 - p1), 32'd1);
        out_ready = 2'b11;
        tick(8);
        check("drain_q0", 32'(exp0.size()), 32'd0);
        check("drain_q1", 32'(exp1.size()), 32'd0);

        // Tag passthrough from input 0; input 1 carries a different tag.
        cfg_data = 5'b1_10_01;
        in_data  = {2'b00, 8'd30, 2'b11, 8'd20};
        in_valid = 2'b11;
        tick(1);
        in_valid = 2'b00;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (out_valid == 2'b11) found = 1'b1;
        end
        check("passthru_seen", 32'(found), 32'd1);
        check("passthru_port0", 32'(out_data[9:0]), 32'({2'b11, 8'd50}));
        check("passthru_port1", 32'(out_data[19:10]), 32'({2'b11, 8'd50}));
        tick(4);

        // Reset with results buffered and in flight.
        cfg_data  = 5'b0_10_01;
        out_ready = 2'b00;
        in_data   = {2'b00, 8'd2, 2'b00, 8'd1};
        in_valid  = 2'b11;
        tick(4);
        check("pre_reset_buffered", 32'(out_valid), 32'd3);
        rst_n = 1'b0;
        exp0.delete();
        exp1.delete();
        #1;
        check("async_reset_out_valid", 32'(out_valid), 32'd0);
        check("async_reset_in_ready", 32'(in_ready), 32'd0);
        out_ready = 2'b11;
        tick(2);
        rst_n = 1'b1;
        f0 = fires;
        p0 = pops0;
        @(negedge clk);
        check("fire_after_release", 32'(in_ready), 32'd3);
        @(posedge clk);
        #1;
        in_valid = 2'b00;
        tick(8);
        check("post_reset_fires", 32'(fires - f0), 32'd1);
        check("post_reset_outputs", 32'(pops0 - p0), 32'd1);
        check("final_q0_empty", 32'(exp0.size()), 32'd0);
        check("final_q1_empty", 32'(exp1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
